id_fetch_buffer: RTL and testbench
==================================

// Module: id_fetch_buffer
// PURPOSE
//  Decode-side instruction buffer between fetch and decode/extend. Queues fetched {pc, instr, pred_taken}
//  in a small FIFO with valid/ready on both sides, decouples fetch from decode stalls, and drops in-flight
//  entries on mispredict flush. Classifies the head instruction's immediate format and presents
//  imm_cntrl/imm_src ready to drive the immediate extender directly.
// PARAMETERS
//  DEPTH      2               FIFO entries; power of two, >= 2
//  XLEN       32              PC / instruction width
//  NOP_INSTR  32'h0000_0013   instruction presented while empty (addi x0,x0,0)
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  reset        in   1        synchronous, active-high
//  flush        in   1        mispredict/redirect: discard all entries
//  in_valid     in   1        fetch presents an entry
//  in_ready     out  1        buffer can accept (registered, not a function of out_ready)
//  in_pc        in   XLEN     PC of fetched instruction
//  in_instr     in   32       fetched instruction word
//  in_pred      in   1        branch predictor taken bit
//  out_valid    out  1        head entry valid
//  out_ready    in   1        decode consumes head
//  out_pc       out  XLEN     head PC
//  out_instr    out  32       head instruction
//  out_pred     out  1        head predictor bit
//  imm_cntrl    out  3        immediate format of head (encoding below)
//  imm_src      out  25       out_instr[31:7]
//  out_illegal  out  1        head opcode not in RV32I base set (qualified by out_valid)
// BEHAVIOUR
//  - Reset (synchronous, active-high): count=0, rd/wr ptr=0, out_valid=0, in_ready=1. Storage not reset.
//  - Push when in_valid&&in_ready; pop when out_valid&&out_ready. Push+pop same cycle: count unchanged, legal
//    when full (in_ready reflects count < DEPTH, so no push when full) and when count==1.
//  - No bypass: entry pushed in cycle N is visible at out_* in cycle N+1 (latency 1). Empty -> no pop.
//  - in_ready = (count < DEPTH), driven from registered count; out_valid = (count != 0).
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//  - flush: next cycle count=0, ptrs=0, out_valid=0, in_ready=1. Flush overrides simultaneous push and pop;
//    the pushed entry is dropped. reset has priority over flush.
//  - Empty outputs: out_instr=NOP_INSTR, out_pc=0, out_pred=0, imm_cntrl=000, out_illegal=0.
//  - imm_cntrl combinational from head opcode (instr[6:0]) / funct3 (instr[14:12]):
//      001 SHAMT  0010011 with funct3 001 or 101
//      010 I      0010011 other funct3; 0000011 load; 1100111 jalr
//      011 S      0100011    100 B 1100011    101 U 0110111/0010111    110 J 1101111
//      000        0110011 R-type, 0001111 fence, 1110011 system, any other opcode
//  - out_illegal=1 for opcodes outside {0110011,0010011,0000011,0100011,1100011,0110111,0010111,1101111,
//    1100111,0001111,1110011} or instr[1:0]!=2'b11; imm_cntrl=000 then.
//  - Outputs stable while out_valid && !out_ready (no flush).
// STRUCTURE
//  - Shared package core_pkg: IMM_TYPE_* localparams (3'b000..3'b110), OPCODE_* constants, NOP_INSTR.
//  - One sub-module: imm_type_decode (instr[31:0] -> imm_cntrl, illegal), purely combinational.
//  - FIFO storage: DEPTH-entry arrays of pc/instr/pred; no sub-module.
// TESTING
//  - Reset then idle: out_valid=0, in_ready=1, out_instr=32'h00000013, imm_cntrl=000.
//  - Push pc=0x100 instr=0x00500093 (addi x1,x0,5), out_ready=0: next cycle out_valid=1, out_pc=0x100,
//    imm_cntrl=010, imm_src=0x00500093>>7; held stable until out_ready=1 pops it.
//  - Fill with 0x00209093 (slli) then 0xFE000EE3 (beq): in_ready=0 after 2nd push; head imm_cntrl=001;
//    push+pop when full blocked; after pop head=beq, imm_cntrl=100, in_ready=1.
//  - Streaming in_valid=out_ready=1 for 8 cycles with pcs 0x0..0x1C: every PC emitted once, in order,
//    count stays 1; pointers wrap cleanly.
//  - Flush with count=2 and simultaneous push: next cycle out_valid=0, in_ready=1, pushed entry absent.
//  - Head 0x0000007F (bad opcode): out_illegal=1, imm_cntrl=000; 0x000000EF (jal): imm_cntrl=110.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants: immediate formats, RV32I base opcodes, canonical NOP.
// Imported by the decode-side fetch buffer and its immediate-type decoder.
package core_pkg;

    localparam logic [2:0] IMM_TYPE_NONE  = 3'b000;
    localparam logic [2:0] IMM_TYPE_SHAMT = 3'b001;
    localparam logic [2:0] IMM_TYPE_I     = 3'b010;
    localparam logic [2:0] IMM_TYPE_S     = 3'b011;
    localparam logic [2:0] IMM_TYPE_B     = 3'b100;
    localparam logic [2:0] IMM_TYPE_U     = 3'b101;
    localparam logic [2:0] IMM_TYPE_J     = 3'b110;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNCT3_SLLI   = 3'b001;
    localparam logic [2:0] FUNCT3_SRXI   = 3'b101;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

endpackage

// File: rtl/imm_type_decode.sv
// Combinational immediate-format classifier for one RV32I instruction word.
// Flags anything outside the RV32I base opcode set as illegal.
module imm_type_decode (
    input  logic [31:0] instr,
    output logic [2:0]  imm_cntrl,
    output logic        illegal
);
    import core_pkg::*;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       unused_fields;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign unused_fields = ^{instr[31:15], instr[11:7]};

    // Every base opcode ends in 2'b11, so bad low bits fall into default.
    always_comb begin
        imm_cntrl = IMM_TYPE_NONE;
        illegal   = 1'b0;
        unique case (1'b1)
            opc == OPCODE_OP_IMM: begin
                if (f3 == FUNCT3_SLLI || f3 == FUNCT3_SRXI)
                    imm_cntrl = IMM_TYPE_SHAMT;
                else
                    imm_cntrl = IMM_TYPE_I;
            end
            opc == OPCODE_LOAD:   imm_cntrl = IMM_TYPE_I;
            opc == OPCODE_JALR:   imm_cntrl = IMM_TYPE_I;
            opc == OPCODE_STORE:  imm_cntrl = IMM_TYPE_S;
            opc == OPCODE_BRANCH: imm_cntrl = IMM_TYPE_B;
            opc == OPCODE_LUI:    imm_cntrl = IMM_TYPE_U;
            opc == OPCODE_AUIPC:  imm_cntrl = IMM_TYPE_U;
            opc == OPCODE_JAL:    imm_cntrl = IMM_TYPE_J;
            opc == OPCODE_OP:     imm_cntrl = IMM_TYPE_NONE;
            opc == OPCODE_FENCE:  imm_cntrl = IMM_TYPE_NONE;
            opc == OPCODE_SYSTEM: imm_cntrl = IMM_TYPE_NONE;
            default: begin
                imm_cntrl = IMM_TYPE_NONE;
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_fetch_buffer.sv
// Fetch-to-decode instruction FIFO with flush, and head immediate-format
// classification feeding the immediate extender.
module id_fetch_buffer #(
    parameter int          DEPTH     = 2,
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            in_pred,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_pred,
    output logic [2:0]      imm_cntrl,
    output logic [24:0]     imm_src,
    output logic            out_illegal
);
    import core_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic            pred_q  [DEPTH];

    logic            push;
    logic            pop;
    logic [2:0]      dec_cntrl;
    logic            dec_illegal;

    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Payload storage is intentionally left unreset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            pc_q[wr_ptr]    <= in_pc;
            instr_q[wr_ptr] <= in_instr;
            pred_q[wr_ptr]  <= in_pred;
        end
    end

    assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_q[rd_ptr] : NOP_INSTR;
    assign out_pred  = out_valid ? pred_q[rd_ptr]  : 1'b0;
    assign imm_src   = out_instr[31:7];

    imm_type_decode u_dec (
        .instr     (out_instr),
        .imm_cntrl (dec_cntrl),
        .illegal   (dec_illegal)
    );

    assign imm_cntrl   = out_valid ? dec_cntrl : IMM_TYPE_NONE;
    assign out_illegal = out_valid && dec_illegal;

endmodule

// File: tb/tb_id_fetch_buffer.sv
// Directed vector bench for id_fetch_buffer (DEPTH=2).
// Inputs applied at negedge; outputs checked 1 time unit later.
module tb_id_fetch_buffer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_pred;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_pred;
    logic [2:0]  imm_cntrl;
    logic [24:0] imm_src;
    logic        out_illegal;

    int n_chk;
    int n_fail;

    id_fetch_buffer #(.DEPTH(2), .XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_pred     (in_pred),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_pred    (out_pred),
        .imm_cntrl   (imm_cntrl),
        .imm_src     (imm_src),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] iins;
        logic        ip;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic [31:0] epc;
        logic [31:0] eins;
        logic        epred;
        logic [2:0]  eic;
        logic        eill;
    } vec_t;

    vec_t vq[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic void add(
        logic fl, logic iv, logic [31:0] ipc, logic [31:0] iins,
        logic ip, logic ordy,
        logic eov, logic eir, logic [31:0] epc, logic [31:0] eins,
        logic epred, logic [2:0] eic, logic eill);
        vec_t v;
        v = '{fl, iv, ipc, iins, ip, ordy,
              eov, eir, epc, eins, epred, eic, eill};
        vq.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic fl, logic iv, logic [31:0] ipc,
                         logic [31:0] iins, logic ip, logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_pc     = ipc;
        in_instr  = iins;
        in_pred   = ip;
        out_ready = ordy;
    endtask

    task automatic chk_all(string tag, vec_t v);
        logic [31:0] esrc;
        esrc = v.eins >> 7;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.eov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.eir));
        chk({tag, ".out_pc"}, out_pc, v.epc);
        chk({tag, ".out_instr"}, out_instr, v.eins);
        chk({tag, ".out_pred"}, 32'(out_pred), 32'(v.epred));
        chk({tag, ".imm_cntrl"}, 32'(imm_cntrl), 32'(v.eic));
        chk({tag, ".illegal"}, 32'(out_illegal), 32'(v.eill));
        chk({tag, ".imm_src"}, 32'(imm_src), esrc);
    endtask

    task automatic chk_empty(string tag);
        vec_t v;
        v = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0,
              1'b0, 1'b1, 32'h0, NOP, 1'b0, 3'd0, 1'b0};
        chk_all(tag, v);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        //   fl iv pc      instr         p  or | ov ir pc     instr         p  ic  il
        add(0, 0, 32'h0,   32'h0,        0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h100, 32'h00500093, 0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 0, 32'h0,   32'h0,        0, 0,  1, 1, 32'h100, 32'h00500093, 0, 2, 0);
        add(0, 0, 32'h0,   32'h0,        0, 0,  1, 1, 32'h100, 32'h00500093, 0, 2, 0);
        add(0, 0, 32'h0,   32'h0,        0, 1,  1, 1, 32'h100, 32'h00500093, 0, 2, 0);
        add(0, 0, 32'h0,   32'h0,        0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h104, 32'h00209093, 1, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h108, 32'hFE000EE3, 0, 0,  1, 1, 32'h104, 32'h00209093, 1, 1, 0);
        add(0, 1, 32'h10C, 32'h00000013, 0, 1,  1, 0, 32'h104, 32'h00209093, 1, 1, 0);
        add(0, 0, 32'h0,   32'h0,        0, 0,  1, 1, 32'h108, 32'hFE000EE3, 0, 4, 0);
        add(0, 0, 32'h0,   32'h0,        0, 1,  1, 1, 32'h108, 32'hFE000EE3, 0, 4, 0);
        add(0, 0, 32'h0,   32'h0,        0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h200, 32'h000000EF, 0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h204, 32'h0000007F, 0, 0,  1, 1, 32'h200, 32'h000000EF, 0, 6, 0);
        add(1, 1, 32'h208, 32'h00500093, 0, 1,  1, 0, 32'h200, 32'h000000EF, 0, 6, 0);
        add(0, 0, 32'h0,   32'h0,        0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h300, 32'h0000007F, 0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(1, 1, 32'h304, 32'h00500093, 0, 0,  1, 1, 32'h300, 32'h0000007F, 0, 0, 1);
        add(0, 0, 32'h0,   32'h0,        0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h400, 32'h00000010, 1, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 0, 32'h0,   32'h0,        0, 1,  1, 1, 32'h400, 32'h00000010, 1, 0, 1);
        add(0, 1, 32'h500, 32'h00112023, 0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);
        add(0, 1, 32'h504, 32'h123450B7, 0, 1,  1, 1, 32'h500, 32'h00112023, 0, 3, 0);
        add(0, 1, 32'h508, 32'h00000097, 0, 1,  1, 1, 32'h504, 32'h123450B7, 0, 5, 0);
        add(0, 1, 32'h50C, 32'h4010D093, 0, 1,  1, 1, 32'h508, 32'h00000097, 0, 5, 0);
        add(0, 1, 32'h510, 32'h0000A083, 0, 1,  1, 1, 32'h50C, 32'h4010D093, 0, 1, 0);
        add(0, 1, 32'h514, 32'h000080E7, 0, 1,  1, 1, 32'h510, 32'h0000A083, 0, 2, 0);
        add(0, 1, 32'h518, 32'h002081B3, 0, 1,  1, 1, 32'h514, 32'h000080E7, 0, 2, 0);
        add(0, 0, 32'h0,   32'h0,        0, 1,  1, 1, 32'h518, 32'h002081B3, 0, 0, 0);
        add(0, 0, 32'h0,   32'h0,        0, 0,  0, 1, 32'h0,   NOP,          0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].fl, vq[i].iv, vq[i].ipc, vq[i].iins,
                  vq[i].ip, vq[i].ordy);
            #1;
            chk_all($sformatf("vec%0d", i), vq[i]);
            @(negedge clk);
        end

        // Streaming push+pop: one entry in flight, pointers wrap four times.
        for (int i = 0; i <= 8; i++) begin
            drive(0, i < 8, 32'(4 * i), 32'h00000093 | (32'(i) << 20), 0, 1);
            #1;
            if (i == 0) begin
                chk_empty("stream0");
            end else begin
                chk($sformatf("stream%0d.out_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
                chk($sformatf("stream%0d.out_pc", i), out_pc, 32'(4 * (i - 1)));
                chk($sformatf("stream%0d.out_instr", i), out_instr,
                    32'h00000093 | (32'(i - 1) << 20));
                chk($sformatf("stream%0d.imm_cntrl", i), 32'(imm_cntrl), 32'd2);
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_empty("stream_end");
        @(negedge clk);

        // Reset while full and pushing empties the buffer.
        drive(0, 1, 32'h600, 32'h000000EF, 1, 0);
        @(negedge clk);
        drive(0, 1, 32'h604, 32'h000000EF, 1, 0);
        @(negedge clk);
        #1;
        chk("full.in_ready", 32'(in_ready), 32'd0);
        chk("full.out_pc", out_pc, 32'h600);
        reset = 1'b1;
        drive(0, 1, 32'h608, 32'h000000EF, 1, 1);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_empty("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
